// File: rtl/fifo_rd_burst_packer.sv
// Read-side burst framer: pops show-ahead FIFO words into sop/eop/len packets on a valid/ready stream.
// Optional partial-burst flush on idle timeout is enabled by defining BURST_TIMEOUT_EN.
module fifo_rd_burst_packer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_fifo_empty,
  input  logic [DEPTH:0]   i_fifo_depth,
  input  logic [WIDTH-1:0] i_fifo_data,
  output logic             o_fifo_rd_en,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sop,
  output logic             o_eop,
  output logic [DEPTH:0]   o_len,
  output logic             o_busy,
  output logic             o_dbg_state
);

  // Stream handshake: a beat transfers on a rising edge where o_valid & i_ready;
  // while o_valid & !i_ready every o_* beat field holds its value.

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             sop;
    logic             eop;
    logic [DEPTH:0]   len;
  } beat_t;

  localparam logic [DEPTH:0] BURST_LEN_W = (DEPTH+1)'(BURST_LEN);
  localparam logic [DEPTH:0] ONE_W       = (DEPTH+1)'(1);

  if (BURST_LEN < 1 || BURST_LEN > (1 << DEPTH) || TIMEOUT < 1) begin : g_param_check
    $error("fifo_rd_burst_packer: BURST_LEN or TIMEOUT out of range");
  end

  state_t         state_q, state_d;
  logic [DEPTH:0] len_q, len_d;
  logic [DEPTH:0] rem_q, rem_d;
  beat_t          skid_q [2];
  beat_t          skid_d [2];
  logic [1:0]     cnt_q, cnt_d;
  logic           push;
  logic           pop_out;
  logic           wr_idx;
  logic           start_full;
  logic           start_partial;

  assign start_full = (i_fifo_depth >= BURST_LEN_W);

`ifdef BURST_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q;
    if (state_q != S_IDLE || i_fifo_depth == '0 || start_full) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_LAST) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  assign start_partial = (tmo_q == TMO_LAST) && (i_fifo_depth != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign start_partial = 1'b0;
`endif

  // Pop permission depends only on registered state, never on i_ready.
  assign o_fifo_rd_en = (state_q == S_BURST) && !i_fifo_empty && (cnt_q < 2'd2);
  assign push         = o_fifo_rd_en;
  assign o_valid      = (cnt_q != 2'd0);
  assign pop_out      = o_valid && i_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (start_full) begin
          len_d   = BURST_LEN_W;
          rem_d   = BURST_LEN_W;
          state_d = S_BURST;
        end else if (start_partial) begin
          len_d   = i_fifo_depth;
          rem_d   = i_fifo_depth;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (push) begin
          rem_d = rem_q - ONE_W;
          if (rem_q == ONE_W) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Entry 0 is the head; a write lands just above whatever survives this cycle's drain.
  assign wr_idx = cnt_q[0] ^ pop_out;

  always_comb begin
    skid_d = skid_q;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop_out};
    if (pop_out) skid_d[0] = skid_q[1];
    if (push) begin
      skid_d[wr_idx] = '{data: i_fifo_data,
                         sop:  (rem_q == len_q),
                         eop:  (rem_q == ONE_W),
                         len:  len_q};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      skid_q[0] <= '0;
      skid_q[1] <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      skid_q[0] <= skid_d[0];
      skid_q[1] <= skid_d[1];
    end
  end

  assign o_data      = skid_q[0].data;
  assign o_sop       = skid_q[0].sop;
  assign o_eop       = skid_q[0].eop;
  assign o_len       = skid_q[0].len;
  assign o_busy      = (state_q != S_IDLE) || (cnt_q != 2'd0);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_fifo_rd_burst_packer.sv
// Bench for fifo_rd_burst_packer: queue-modelled show-ahead FIFO, packet-framing reference model and
// a beat scoreboard. Framing expectations follow BURST_TIMEOUT_EN when it is defined.
module tb_fifo_rd_burst_packer;
  localparam int WIDTH     = 8;
  localparam int DEPTH     = 8;
  localparam int BURST_LEN = 16;
  localparam int TIMEOUT   = 64;
  localparam int BW        = WIDTH + 2 + DEPTH + 1;

  logic             i_clk;
  logic             i_rst;
  logic             i_fifo_empty;
  logic [DEPTH:0]   i_fifo_depth;
  logic [WIDTH-1:0] i_fifo_data;
  logic             o_fifo_rd_en;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_sop;
  logic             o_eop;
  logic [DEPTH:0]   o_len;
  logic             o_busy;
  logic             o_dbg_state;

  fifo_rd_burst_packer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_fifo_empty(i_fifo_empty), .i_fifo_depth(i_fifo_depth),
    .i_fifo_data(i_fifo_data), .o_fifo_rd_en(o_fifo_rd_en), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_sop(o_sop), .o_eop(o_eop), .o_len(o_len), .o_busy(o_busy),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ---------------- shared state ----------------
  logic [BW-1:0]    exp_q [$];
  logic [WIDTH-1:0] fifo_q [$];
  logic [WIDTH-1:0] pend_q [$];
  int               n_vec = 0;
  int               n_err = 0;
  int               pops = 0;
  int               beats = 0;
  int               beat_mark = 0;
  int               ready_mode = 1;
  logic             pop_pend = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] mk_beat(input logic [WIDTH-1:0] d, input logic sop,
                                            input logic eop, input int len);
    return {d, sop, eop, (DEPTH+1)'(len)};
  endfunction

  // ---------------- reference model ----------------
  // Words leave the FIFO in order; every BURST_LEN of them form one packet.
  task automatic frame_full();
    while (pend_q.size() >= BURST_LEN) begin
      for (int i = 0; i < BURST_LEN; i++)
        exp_q.push_back(mk_beat(pend_q.pop_front(), i == 0, i == BURST_LEN - 1, BURST_LEN));
    end
  endtask

  // With the timeout, leftovers of a single write are flushed as one short packet.
  task automatic flush_residual();
    int n;
    n = pend_q.size();
    for (int i = 0; i < n; i++)
      exp_q.push_back(mk_beat(pend_q.pop_front(), i == 0, i == n - 1, n));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_fifo();
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_depth = (DEPTH+1)'(fifo_q.size());
    i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic write_words(input int n);
    logic [WIDTH-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      fifo_q.push_back(d);
      pend_q.push_back(d);
    end
    frame_full();
`ifdef BURST_TIMEOUT_EN
    flush_residual();
`endif
    drive_fifo();
  endtask

  always @(negedge i_clk) pop_pend = o_fifo_rd_en;

  task automatic step();
    @(posedge i_clk);
    #1;
    if (pop_pend) begin
      check("pop_from_nonempty", fifo_q.size() != 0, 1);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pops++;
    end
    case (ready_mode)
      0:       i_ready = 1'b0;
      1:       i_ready = 1'b1;
      2:       i_ready = ($urandom_range(0, 3) != 0);
      default: i_ready = (beats <= beat_mark);
    endcase
    drive_fifo();
  endtask

  task automatic do_reset(input int n);
    i_rst = 1'b1;
    repeat (n) @(posedge i_clk);
    #1;
    fifo_q.delete();
    pend_q.delete();
    exp_q.delete();
    pops  = 0;
    i_rst = 1'b0;
    drive_fifo();
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || o_busy) && c < budget) begin
      step();
      c++;
    end
    check("drain_in_time", c < budget, 1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic                              hold = 1'b0;
  logic [WIDTH+DEPTH+2:0]            held;

  always @(negedge i_clk) begin
    logic [BW-1:0]    e;
    logic [DEPTH:0]   e_len;
    logic [DEPTH:0]   a_len;
    if (i_rst) begin
      beats = 0;
      hold  = 1'b0;
    end else begin
      check("valid_vs_buffered", o_valid, (pops - beats) != 0);
      if (o_fifo_rd_en) check("rd_en_room", (pops - beats) < 2, 1);
      if (hold) check("held_stable", {o_valid, o_data, o_sop, o_eop, o_len}, {1'b1, held});
      if (o_valid && i_ready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e     = exp_q.pop_front();
          e_len = e[DEPTH+2] ? e[DEPTH:0] : '0;
          a_len = e[DEPTH+2] ? o_len : '0;
          check("beat", {o_data, o_sop, o_eop, a_len}, {e[BW-1:DEPTH+1], e_len});
        end
        beats++;
      end
      hold = o_valid && !i_ready;
      held = {o_data, o_sop, o_eop, o_len};
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int pmark;
    int c;
    i_rst        = 1'b1;
    i_ready      = 1'b0;
    i_fifo_empty = 1'b1;
    i_fifo_depth = '0;
    i_fifo_data  = '0;

    // Reset state
    do_reset(2);
    check("rst_valid", o_valid, 0);
    check("rst_rd_en", o_fifo_rd_en, 0);
    check("rst_busy", o_busy, 0);
    check("rst_len", o_len, 0);
    check("rst_sop_eop", {o_sop, o_eop}, 0);
    check("rst_state", o_dbg_state, 0);

    // Full burst, free-flowing
    ready_mode = 1;
    pmark = pops;
    step();
    write_words(BURST_LEN);
    wait_drain(300);
    repeat (5) step();
    check("full_burst_pops", pops - pmark, BURST_LEN);
    check("full_burst_idle", o_dbg_state, 0);

    // Backpressure after the first beat
    beat_mark  = beats;
    ready_mode = 3;
    pmark = pops;
    step();
    write_words(BURST_LEN);
    repeat (30) step();
    check("bp_pops_stalled", pops - pmark, 3);
    check("bp_valid_held", o_valid, 1);
    ready_mode = 1;
    wait_drain(300);
    check("bp_total_pops", pops - pmark, BURST_LEN);

    // Short residual: flushed by timeout, or left in the FIFO without it
    pmark = pops;
    step();
    write_words(3);
`ifdef BURST_TIMEOUT_EN
    c = 0;
    while (!o_fifo_rd_en && c < 200) begin
      step();
      c++;
    end
    check("timeout_latency", c, TIMEOUT);
    wait_drain(300);
    check("timeout_pops", pops - pmark, 3);

    // Single word flush
    pmark = pops;
    step();
    write_words(1);
    wait_drain(300);
    check("single_pops", pops - pmark, 1);
`else
    repeat (1000) step();
    check("no_timeout_pops", pops - pmark, 0);
    check("no_timeout_busy", o_busy, 0);
`endif

    // Reset in the middle of a burst
    pmark = pops;
    step();
    write_words(BURST_LEN);
    c = 0;
    while (pops - pmark < 5 && c < 100) begin
      step();
      c++;
    end
    check("midburst_reached", pops - pmark >= 5, 1);
    do_reset(1);
    check("midrst_valid", o_valid, 0);
    check("midrst_state", o_dbg_state, 0);
    pmark = pops;
    step();
    write_words(BURST_LEN);
    wait_drain(300);
    check("refill_pops", pops - pmark, BURST_LEN);

    // Randomized traffic with random backpressure
    ready_mode = 2;
    for (int p = 0; p < 12; p++) begin
      step();
      write_words($urandom_range(1, 40));
      wait_drain(2000);
      repeat ($urandom_range(0, 10)) step();
    end

    ready_mode = 1;
    repeat (20) step();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
